// File: rtl/ballot_collector_if.sv
// Handshake bundle between the ballot collector, the voter panel and the result consumer.
interface ballot_collector_if;
    logic       start;
    logic       vote_valid;
    logic       vote_bit;
    logic       result_ack;
    logic       req;
    logic [2:0] sel;
    logic       busy;
    logic [4:0] ballot;
    logic [4:0] abstain;
    logic       g;
    logic       result_valid;

    // The collector drives polling and result signals
    modport master (
        input  start, vote_valid, vote_bit, result_ack,
        output req, sel, busy, ballot, abstain, g, result_valid
    );

    // Voter panel and consumer drive the requests, votes and acknowledge
    modport slave (
        output start, vote_valid, vote_bit, result_ack,
        input  req, sel, busy, ballot, abstain, g, result_valid
    );
endinterface

// File: rtl/ballot_collector.sv
// Polls five voters in turn (s2, s1, s0, teacher, principal), records each ballot
// bit or a timeout abstention, then presents the two-level majority decision.
module ballot_collector #(
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    ballot_collector_if.master bus
);

    typedef enum logic [1:0] {IDLE, POLL, EVAL, DONE} state_t;

    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] tcnt;
    logic [2:0] idx;
    logic [2:0] pos;
    logic [4:0] ballot_r;
    logic [4:0] abstain_r;
    logic       g_r;
    logic       timeout_hit;
    logic       advance;
    logic       student_maj;

    // Ballot vector is stored with s2 in the MSB, so voter idx lands in bit 4-idx
    assign pos         = 3'd4 - idx;
    assign timeout_hit = (tcnt == TCNT_LAST);
    assign advance     = bus.vote_valid || timeout_hit;
    assign student_maj = (ballot_r[4] & ballot_r[3]) | (ballot_r[4] & ballot_r[2]) |
                         (ballot_r[3] & ballot_r[2]);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; the last voter finishing moves on to evaluation
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = POLL;
            POLL: if (advance && idx == 3'd4) state_next = EVAL;
            EVAL: state_next = DONE;
            DONE: if (bus.result_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ballot capture, timeout counting, voter stepping and decision evaluation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt      <= '0;
            idx       <= '0;
            ballot_r  <= '0;
            abstain_r <= '0;
            g_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ballot_r  <= '0;
                        abstain_r <= '0;
                        idx       <= '0;
                        tcnt      <= '0;
                    end
                end
                POLL: begin
                    if (bus.vote_valid) begin
                        ballot_r[pos] <= bus.vote_bit;
                        tcnt          <= '0;
                    end else if (timeout_hit) begin
                        ballot_r[pos]  <= 1'b0;
                        abstain_r[pos] <= 1'b1;
                        tcnt           <= '0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                    if (advance && idx != 3'd4) begin
                        idx <= idx + 3'd1;
                    end
                end
                EVAL: begin
                    g_r <= (student_maj & ballot_r[1]) | (student_maj & ballot_r[0]) |
                           (ballot_r[1] & ballot_r[0]);
                end
                default: begin
                end
            endcase
        end
    end

    // Status and handshake outputs decoded from the current state
    always_comb begin
        bus.req          = (state == POLL);
        bus.sel          = (state == POLL) ? idx : 3'd0;
        bus.busy         = (state != IDLE);
        bus.result_valid = (state == DONE);
        bus.ballot       = ballot_r;
        bus.abstain      = abstain_r;
        bus.g            = g_r;
    end

endmodule
